multi_tick_gen: RTL and testbench

Parametrised multi-channel tick generator for the watch/sensor system. A base prescaler divides `clk` down to a base tick, 1 MHz by default. `NCH` independent channel counters divide that base tick further, giving aligned single-cycle enables such as 1 kHz, 100 Hz and 1 Hz for the SR04 timing, display scan and timekeeping blocks. Channel divisors can be reloaded at runtime without glitches, and the global enable, per-channel enables and synchronous clear allow the timebase to be paused and resynchronised.

---
 rtl/multi_tick_gen.sv | 147 ++++++++++++++
 tb/tb_multi_tick_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: base prescaler feeding NCH aligned divided tick channels.
// Define TICK_GEN_LOAD_EN to compile in glitch-free runtime divisor loads.
module multi_tick_gen #(
  parameter int SYS_CLK = 100_000_000,
  parameter int BASE_CLK = 1_000_000,
  parameter int NCH = 4,
  parameter int CW = 20,
  parameter logic [NCH*CW-1:0] DIV_INIT =
    {20'd1_000_000, 20'd10_000, 20'd1_000, 20'd1},
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_clr,
  input  logic [NCH-1:0] i_ch_en,
  input  logic           i_ld_valid,
  input  logic [CHW-1:0] i_ld_ch,
  input  logic [CW-1:0]  i_ld_div,
  output logic           o_ld_ready,
  output logic           o_ld_err,
  output logic           o_base_tick,
  output logic [NCH-1:0] o_tick
);

  localparam int TCNT = SYS_CLK / BASE_CLK;
  localparam int PW = ($clog2(TCNT) > 1) ? $clog2(TCNT) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TCNT - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic base_tick_q, base_tick_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CW-1:0] div_w;
  logic [NCH-1:0] cw;
  logic bw;

  assign bw = i_en & (pcnt_q == PMAX);
  assign o_base_tick = base_tick_q;
  assign o_tick = tick_q;

`ifdef TICK_GEN_LOAD_EN
  localparam int NX = 2 ** CHW;

  logic [NCH-1:0][CW-1:0] div_q, div_d;
  logic [NCH-1:0][CW-1:0] sdiv_q, sdiv_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NX-1:0] pend_x;
  logic ld_err_q, ld_err_d;
  logic ch_ok, ld_ready, ld_ok;

  // Out-of-range channels read as not pending so the bad load is taken and flagged.
  assign pend_x = NX'(pend_q);
  assign ch_ok = int'(i_ld_ch) < NCH;
  assign ld_ready = ~pend_x[i_ld_ch];
  assign ld_ok = i_ld_valid & ld_ready;
  assign div_w = div_q;
  assign o_ld_ready = ld_ready;
  assign o_ld_err = ld_err_q;
`else
  logic unused_ld;

  assign unused_ld = ^{i_ld_valid, i_ld_ch, i_ld_div};
  assign div_w = DIV_INIT;
  assign o_ld_ready = 1'b0;
  assign o_ld_err = 1'b0;
`endif

  always_comb begin
    pcnt_d = pcnt_q;
    base_tick_d = bw;
    cnt_d = cnt_q;
    tick_d = '0;
    cw = '0;
`ifdef TICK_GEN_LOAD_EN
    div_d = div_q;
    sdiv_d = sdiv_q;
    pend_d = pend_q;
    ld_err_d = 1'b0;
`endif
    if (i_clr) begin
      pcnt_d = '0;
      base_tick_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (bw) pcnt_d = '0;
      else if (i_en) pcnt_d = pcnt_q + PW'(1);
      for (int i = 0; i < NCH; i++) begin
        if (!i_ch_en[i]) begin
          cnt_d[i] = '0;
        end else if (bw) begin
          if (cnt_q[i] == div_w[i] - CW'(1)) begin
            cnt_d[i] = '0;
            cw[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end
      tick_d = cw;
    end
`ifdef TICK_GEN_LOAD_EN
    // A new divisor only lands where a period starts afresh from zero.
    for (int i = 0; i < NCH; i++) begin
      if (pend_q[i] & (i_clr | cw[i] | ~i_ch_en[i])) begin
        div_d[i] = sdiv_q[i];
        pend_d[i] = 1'b0;
      end
    end
    if (ld_ok) begin
      if (ch_ok && i_ld_div != '0) begin
        sdiv_d[i_ld_ch] = i_ld_div;
        pend_d[i_ld_ch] = 1'b1;
      end else begin
        ld_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      base_tick_q <= 1'b0;
      tick_q <= '0;
      cnt_q <= '0;
`ifdef TICK_GEN_LOAD_EN
      div_q <= DIV_INIT;
      sdiv_q <= '0;
      pend_q <= '0;
      ld_err_q <= 1'b0;
`endif
    end else begin
      pcnt_q <= pcnt_d;
      base_tick_q <= base_tick_d;
      tick_q <= tick_d;
      cnt_q <= cnt_d;
`ifdef TICK_GEN_LOAD_EN
      div_q <= div_d;
      sdiv_q <= sdiv_d;
      pend_q <= pend_d;
      ld_err_q <= ld_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: scoreboarded tick pulses plus table-driven load vectors.
// TCNT = 10, two channels with reset divisors 1 and 3.
module tb_multi_tick_gen;

`ifdef TICK_GEN_LOAD_EN
  localparam bit LD_EN = 1'b1;
`else
  localparam bit LD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_en = 1'b0;
  logic i_clr = 1'b0;
  logic [1:0] i_ch_en = '0;
  logic i_ld_valid = 1'b0;
  logic [0:0] i_ld_ch = '0;
  logic [3:0] i_ld_div = '0;
  logic o_ld_ready, o_ld_err, o_base_tick;
  logic [1:0] o_tick;

  always #5 clk = ~clk;

  multi_tick_gen #(
    .SYS_CLK(100),
    .BASE_CLK(10),
    .NCH(2),
    .CW(4),
    .DIV_INIT({4'd3, 4'd1})
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_en(i_en),
    .i_clr(i_clr),
    .i_ch_en(i_ch_en),
    .i_ld_valid(i_ld_valid),
    .i_ld_ch(i_ld_ch),
    .i_ld_div(i_ld_div),
    .o_ld_ready(o_ld_ready),
    .o_ld_err(o_ld_err),
    .o_base_tick(o_base_tick),
    .o_tick(o_tick)
  );

  typedef struct {
    int e;
    logic [2:0] v;
  } ev_t;

  typedef struct {
    logic ch;
    logic [3:0] div;
    logic acc;
  } ld_vec_t;

  ev_t exp_q[$];
  ld_vec_t tbl[5];
  int n, n_chk, n_pass;
  bit mon_en = 1'b0;
  logic [2:0] mv;
  ev_t mev;

  // Edge number since reset release.
  always @(posedge clk) begin
    if (rst) n = 0;
    else n = n + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d",
                  nm, act, exp, n);
  endtask

  // Scoreboard: any pulse must match the front expected event.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mv = {o_tick, o_base_tick};
      if (exp_q.size() > 0 && exp_q[0].e == n) begin
        mev = exp_q.pop_front();
        chk($sformatf("pulse@%0d", n), 32'(mv), 32'(mev.v));
      end else if (mv != 3'b000) begin
        chk($sformatf("stray@%0d", n), 32'(mv), 32'd0);
      end
    end
  end

  task automatic add(input int e, input int b);
    ev_t x;
    int i = 0;
    while (i < exp_q.size() && exp_q[i].e < e) i++;
    if (i < exp_q.size() && exp_q[i].e == e) begin
      x = exp_q[i];
      x.v[b] = 1'b1;
      exp_q[i] = x;
    end else begin
      x.e = e;
      x.v = '0;
      x.v[b] = 1'b1;
      exp_q.insert(i, x);
    end
  endtask

  task automatic series(input int first, input int per, input int last,
                        input int b);
    for (int e = first; e <= last; e += per) add(e, b);
  endtask

  task automatic wait_n(input int k);
    int g = 0;
    while (n < k && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (n != k) chk("wait_edge", n, k);
  endtask

  task automatic finish_scn(input string nm, input int last);
    wait_n(last);
    chk({nm, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    i_en = 1'b0;
    i_clr = 1'b0;
    i_ch_en = '0;
    i_ld_valid = 1'b0;
    i_ld_ch = '0;
    i_ld_div = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic start();
    i_en = 1'b1;
    i_ch_en = 2'b11;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, d0, d1;
    tbl[0] = '{ch: 1'b1, div: 4'd0, acc: 1'b0};
    tbl[1] = '{ch: 1'b0, div: 4'd0, acc: 1'b0};
    tbl[2] = '{ch: 1'b1, div: 4'd2, acc: 1'b1};
    tbl[3] = '{ch: 1'b0, div: 4'd3, acc: 1'b1};
    tbl[4] = '{ch: 1'b1, div: 4'd0, acc: 1'b0};
    n_chk = 0;
    n_pass = 0;

    repeat (2) @(negedge clk);
    chk("rst_base", o_base_tick, 0);
    chk("rst_tick", o_tick, 0);
    chk("rst_err", o_ld_err, 0);
    chk("rst_ready", o_ld_ready, LD_EN);

    // Free run
    do_reset();
    start();
    series(10, 10, 90, 0);
    series(10, 10, 90, 1);
    series(30, 30, 90, 2);
    finish_scn("run", 95);

    // Pause for 5 cycles from edge 14
    do_reset();
    start();
    add(10, 0);
    add(10, 1);
    series(25, 10, 95, 0);
    series(25, 10, 95, 1);
    series(35, 30, 95, 2);
    wait_n(13);
    i_en = 1'b0;
    wait_n(18);
    i_en = 1'b1;
    finish_scn("pause", 98);

    // Load ch1 divisor 2 at edge 12
    do_reset();
    start();
    series(10, 10, 90, 0);
    series(10, 10, 90, 1);
    if (LD_EN) series(30, 20, 90, 2);
    else series(30, 30, 90, 2);
    wait_n(11);
    i_ld_valid = 1'b1;
    i_ld_ch = 1'b1;
    i_ld_div = 4'd2;
    chk("ld_ready_pre", o_ld_ready, LD_EN);
    wait_n(12);
    i_ld_valid = 1'b0;
    chk("ld_ready_12", o_ld_ready, 0);
    wait_n(29);
    chk("ld_ready_29", o_ld_ready, 0);
    wait_n(30);
    chk("ld_ready_30", o_ld_ready, LD_EN);
    finish_scn("load", 95);

    // Rejected zero divisor
    do_reset();
    start();
    series(10, 10, 60, 0);
    series(10, 10, 60, 1);
    series(30, 30, 60, 2);
    wait_n(11);
    i_ld_valid = 1'b1;
    i_ld_ch = 1'b1;
    i_ld_div = 4'd0;
    chk("rej_ready_pre", o_ld_ready, LD_EN);
    wait_n(12);
    i_ld_valid = 1'b0;
    chk("rej_err", o_ld_err, LD_EN);
    chk("rej_ready", o_ld_ready, LD_EN);
    wait_n(13);
    chk("rej_err_end", o_ld_err, 0);
    finish_scn("reject", 65);

    // Synchronous clear at edge 25
    do_reset();
    start();
    add(10, 0);
    add(10, 1);
    add(20, 0);
    add(20, 1);
    series(35, 10, 95, 0);
    series(35, 10, 95, 1);
    series(55, 30, 95, 2);
    wait_n(24);
    i_clr = 1'b1;
    wait_n(25);
    i_clr = 1'b0;
    finish_scn("clr", 98);

    // Async reset at edge 17 with a load pending
    do_reset();
    start();
    add(10, 0);
    add(10, 1);
    wait_n(11);
    i_ld_valid = 1'b1;
    i_ld_ch = 1'b1;
    i_ld_div = 4'd2;
    wait_n(12);
    i_ld_valid = 1'b0;
    finish_scn("pre_rst", 17);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_base", o_base_tick, 0);
    chk("arst_tick", o_tick, 0);
    chk("arst_err", o_ld_err, 0);
    chk("arst_ready", o_ld_ready, LD_EN);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    series(10, 10, 60, 0);
    series(10, 10, 60, 1);
    series(30, 30, 60, 2);
    finish_scn("post_rst", 65);

    // Table of loads with the timebase stopped and channels off
    do_reset();
    for (int r = 0; r < 5; r++) begin
      k = n;
      i_ld_valid = 1'b1;
      i_ld_ch = tbl[r].ch;
      i_ld_div = tbl[r].div;
      chk($sformatf("tbl%0d_rdy_pre", r), o_ld_ready, LD_EN);
      wait_n(k + 1);
      i_ld_valid = 1'b0;
      chk($sformatf("tbl%0d_err", r), o_ld_err, LD_EN & ~tbl[r].acc);
      chk($sformatf("tbl%0d_rdy", r), o_ld_ready, LD_EN & ~tbl[r].acc);
      wait_n(k + 2);
      chk($sformatf("tbl%0d_rdy_end", r), o_ld_ready, LD_EN);
      chk($sformatf("tbl%0d_err_end", r), o_ld_err, 0);
    end
    d0 = LD_EN ? 3 : 1;
    d1 = LD_EN ? 2 : 3;
    k = n;
    series(k + 10, 10, k + 60, 0);
    series(k + 10 * d0, 10 * d0, k + 60, 1);
    series(k + 10 * d1, 10 * d1, k + 60, 2);
    start();
    finish_scn("tbl_run", k + 65);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
